// File: rtl/keypad_pkg.sv
// Shared types and widths for the keypad event path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package keypad_pkg;

  localparam int KEY_W = 4;

  // Debounce FSM states
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } deb_state_t;

endpackage

// File: rtl/key_frame_accumulator.sv
// Folds the per-column scanner hits of one 4-column frame into a frame summary.
// Latency: summary pulses f_valid one cycle after the scan_last cycle.
// Backpressure: none; the scanner free-runs and every frame is reported.
module key_frame_accumulator
  import keypad_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             scan_hit,
  input  logic [KEY_W-1:0] scan_code,
  input  logic             scan_last,
  output logic             f_valid,
  output logic             f_press,
  output logic [KEY_W-1:0] f_code,
  output logic             f_multi
);

  logic             hit;
  logic             multi;
  logic [KEY_W-1:0] code;

  logic             hit_nxt;
  logic             multi_nxt;
  logic [KEY_W-1:0] code_nxt;

  // Fold this cycle's column result into the running frame state
  always_comb begin
    hit_nxt   = hit | scan_hit;
    code_nxt  = (scan_hit && !hit) ? scan_code : code;
    multi_nxt = multi | (scan_hit && hit && (scan_code != code));
  end

  // Publish the frame summary on the cycle after scan_last and restart accumulation
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit     <= 1'b0;
      multi   <= 1'b0;
      code    <= '0;
      f_valid <= 1'b0;
      f_press <= 1'b0;
      f_code  <= '0;
      f_multi <= 1'b0;
    end else begin
      f_valid <= scan_last;
      if (scan_last) begin
        f_press <= hit_nxt & ~multi_nxt;
        f_code  <= code_nxt;
        f_multi <= multi_nxt;
        hit     <= 1'b0;
        multi   <= 1'b0;
        code    <= '0;
      end else begin
        hit     <= hit_nxt;
        multi   <= multi_nxt;
        code    <= code_nxt;
      end
    end
  end

endmodule

// File: rtl/key_event_debounce.sv
// Debounces keypad scan frames and emits one event per accepted key press.
// Latency: scan_last at T -> key_valid/key_down updated at T+2.
// Backpressure: single-entry event register; a press arriving while it is full and not draining is dropped with an overrun pulse.
module key_event_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int CNT_W           = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             scan_hit,
  input  logic [KEY_W-1:0] scan_code,
  input  logic             scan_last,
  output logic             key_valid,
  output logic [KEY_W-1:0] key_code,
  input  logic             key_ready,
  output logic             key_down,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] DF  = CNT_W'(DEBOUNCE_FRAMES);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic             f_valid;
  logic             f_press;
  logic [KEY_W-1:0] f_code;
  logic             f_multi;

  key_frame_accumulator u_acc (
    .clock     (clock),
    .reset     (reset),
    .scan_hit  (scan_hit),
    .scan_code (scan_code),
    .scan_last (scan_last),
    .f_valid   (f_valid),
    .f_press   (f_press),
    .f_code    (f_code),
    .f_multi   (f_multi)
  );

  deb_state_t       state;
  deb_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic [KEY_W-1:0] cand;
  logic [KEY_W-1:0] cand_nxt;
  logic             f_empty;
  logic             emit;

  // Frame classification and saturating frame counter increment
  always_comb begin
    f_empty = !f_press && !f_multi;
    cnt_inc = (cnt >= DF) ? DF : cnt + ONE;
  end

  // Debounce decision: advances only when a frame summary arrives
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cand_nxt  = cand;
    emit      = 1'b0;
    if (f_valid) begin
      case (state)
        IDLE: begin
          if (f_press) begin
            cand_nxt = f_code;
            cnt_nxt  = ONE;
            if (DF == ONE) begin
              state_nxt = HELD;
              emit      = 1'b1;
            end else begin
              state_nxt = PRESS_WAIT;
            end
          end
        end
        PRESS_WAIT: begin
          if (f_press && (f_code == cand)) begin
            cnt_nxt = cnt_inc;
            if (cnt_inc == DF) begin
              state_nxt = HELD;
              emit      = 1'b1;
            end
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end
        HELD: begin
          if (f_empty) begin
            if (DF == ONE) begin
              state_nxt = IDLE;
              cnt_nxt   = '0;
            end else begin
              state_nxt = RELEASE_WAIT;
              cnt_nxt   = ONE;
            end
          end else begin
            cnt_nxt = '0;
          end
        end
        RELEASE_WAIT: begin
          if (f_empty) begin
            cnt_nxt = cnt_inc;
            if (cnt_inc == DF) begin
              state_nxt = IDLE;
              cnt_nxt   = '0;
            end
          end else begin
            state_nxt = HELD;
            cnt_nxt   = '0;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // FSM state, counter, candidate code and the registered key_down level
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      cand     <= '0;
      key_down <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      cand     <= cand_nxt;
      key_down <= (state_nxt == HELD) || (state_nxt == RELEASE_WAIT);
    end
  end

  // Single-entry event register; emit on an occupied, non-draining slot is dropped
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      key_valid <= 1'b0;
      key_code  <= '0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (emit) begin
        if (!key_valid || key_ready) begin
          key_valid <= 1'b1;
          key_code  <= f_code;
        end else begin
          overrun <= 1'b1;
        end
      end else if (key_valid && key_ready) begin
        key_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_key_event_debounce.sv
// Bench for key_event_debounce: frame-level reference model plus directed literal checks.
// Latency: model applies each frame result two cycles after its scan_last cycle.
// Backpressure: key_ready is driven by the stimulus (fixed in directed parts, random later).
module tb_key_event_debounce;
  import keypad_pkg::*;

  localparam int DF = 4;

  logic       clock     = 1'b0;
  logic       reset     = 1'b1;
  logic       scan_hit  = 1'b0;
  logic [3:0] scan_code = 4'h0;
  logic       scan_last = 1'b0;
  logic       key_ready = 1'b1;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_down;
  logic       overrun;

  int vectors     = 0;
  int miscompares = 0;
  int ev_count    = 0;
  int ovr_count   = 0;
  bit rand_ready  = 1'b0;

  always #5 clock = ~clock;

  key_event_debounce #(.DEBOUNCE_FRAMES(DF), .CNT_W(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .scan_hit  (scan_hit),
    .scan_code (scan_code),
    .scan_last (scan_last),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready),
    .key_down  (key_down),
    .overrun   (overrun)
  );

  // ---------------- reference model (frame level) ----------------
  bit          m_valid;
  logic [3:0]  m_code;
  bit          m_down;
  bit          m_ovr;
  int          run_len;
  int          rel_len;
  logic [3:0]  run_code;
  logic [15:0] acc_mask;
  logic [15:0] fr_mask;
  bit          fr_pend;
  bit          m_emit;
  logic [3:0]  m_ecode;
  bit          m_was_valid;
  int          m_n;
  bit          m_p;
  bit          m_mu;
  logic [3:0]  m_c;

  function automatic int popc(input logic [15:0] m);
    int n = 0;
    for (int i = 0; i < 16; i++) if (m[i]) n++;
    return n;
  endfunction

  function automatic logic [3:0] some_idx(input logic [15:0] m);
    logic [3:0] r = 4'h0;
    for (int i = 0; i < 16; i++) if (m[i]) r = 4'(i);
    return r;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_valid = 0; m_code = 4'h0; m_down = 0; m_ovr = 0;
      run_len = 0; rel_len = 0; run_code = 4'h0;
      acc_mask = 16'h0; fr_mask = 16'h0; fr_pend = 0;
    end else begin
      m_emit = 0;
      m_ecode = 4'h0;
      if (fr_pend) begin
        m_n  = popc(fr_mask);
        m_p  = (m_n == 1);
        m_mu = (m_n > 1);
        m_c  = some_idx(fr_mask);
        if (!m_down) begin
          if (run_len == 0) begin
            if (m_p) begin run_code = m_c; run_len = 1; end
          end else if (m_p && m_c == run_code) begin
            run_len++;
          end else begin
            run_len = 0;
          end
          if (run_len >= DF) begin
            m_down = 1; run_len = 0; rel_len = 0;
            m_emit = 1; m_ecode = run_code;
          end
        end else begin
          if (!m_p && !m_mu) rel_len++;
          else rel_len = 0;
          if (rel_len >= DF) begin m_down = 0; rel_len = 0; end
        end
      end
      m_was_valid = m_valid;
      m_ovr = 0;
      if (m_emit) begin
        if (!m_was_valid || key_ready) begin m_valid = 1; m_code = m_ecode; end
        else m_ovr = 1;
      end else if (m_was_valid && key_ready) begin
        m_valid = 0;
      end
      if (scan_hit) acc_mask[scan_code] = 1'b1;
      fr_pend = scan_last;
      if (scan_last) begin fr_mask = acc_mask; acc_mask = 16'h0; end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    vectors++;
    if (key_valid !== m_valid || key_code !== m_code || key_down !== m_down || overrun !== m_ovr) begin
      miscompares++;
      $display("FAIL cycle_compare t=%0t got valid=%b code=%h down=%b ovr=%b expected valid=%b code=%h down=%b ovr=%b",
               $time, key_valid, key_code, key_down, overrun, m_valid, m_code, m_down, m_ovr);
    end
    if (key_valid && key_ready) ev_count++;
    if (overrun) ovr_count++;
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input bit h, input logic [3:0] c, input bit l);
    scan_hit  = h;
    scan_code = h ? c : 4'($urandom);
    scan_last = l;
    if (rand_ready) key_ready = ($urandom_range(0, 9) < 7);
    @(posedge clock);
    #1;
  endtask

  task automatic frame(input logic [4:0] p0, input logic [4:0] p1, input logic [4:0] p2, input logic [4:0] p3);
    cyc(p0[4], p0[3:0], 1'b0);
    cyc(p1[4], p1[3:0], 1'b0);
    cyc(p2[4], p2[3:0], 1'b0);
    cyc(p3[4], p3[3:0], 1'b1);
  endtask

  task automatic frame_key(input logic [3:0] c);
    frame(5'h00, {1'b1, c}, 5'h00, 5'h00);
  endtask

  task automatic frame_empty();
    frame(5'h00, 5'h00, 5'h00, 5'h00);
  endtask

  task automatic frame_multi(input logic [3:0] a, input logic [3:0] b);
    frame({1'b1, a}, 5'h00, {1'b1, b}, 5'h00);
  endtask

  task automatic frame_random(inout logic [3:0] cur);
    logic [4:0] p [4];
    int r;
    int col;
    for (int i = 0; i < 4; i++) p[i] = 5'h00;
    r = $urandom_range(0, 9);
    col = $urandom_range(0, 3);
    if (r == 9) cur = 4'($urandom);
    if (r <= 5 || r == 9) begin
      p[col] = {1'b1, cur};
      if (r == 5) p[(col + 2) % 4] = {1'b1, cur};
    end else if (r == 8) begin
      p[col] = {1'b1, cur};
      p[(col + 1) % 4] = {1'b1, cur ^ 4'($urandom_range(1, 15))};
    end
    frame(p[0], p[1], p[2], p[3]);
  endtask

  // ---------------- directed + random sequence ----------------
  int e0;
  int o0;
  logic [3:0] cur_key;

  initial begin
    repeat (3) @(posedge clock);
    #1;
    chk("reset_valid", int'(key_valid), 0);
    chk("reset_code", int'(key_code), 0);
    chk("reset_down", int'(key_down), 0);
    chk("reset_overrun", int'(overrun), 0);
    reset = 1'b0;

    // single clean press of 0x5 with consumer ready
    e0 = ev_count;
    repeat (4) frame_key(4'h5);
    chk("s1_valid_at_t1", int'(key_valid), 0);
    cyc(1'b0, 4'h0, 1'b0);
    chk("s1_valid_at_t2", int'(key_valid), 1);
    chk("s1_code", int'(key_code), 5);
    chk("s1_down", int'(key_down), 1);
    chk("s1_model_valid", int'(m_valid), 1);
    cyc(1'b0, 4'h0, 1'b0);
    chk("s1_valid_one_cycle", int'(key_valid), 0);
    cyc(1'b0, 4'h0, 1'b0);
    cyc(1'b0, 4'h0, 1'b1);
    repeat (2) frame_empty();
    frame_empty();
    chk("s1_down_before_release", int'(key_down), 1);
    cyc(1'b0, 4'h0, 1'b0);
    chk("s1_down_released", int'(key_down), 0);
    chk("s1_model_down", int'(m_down), 0);
    cyc(1'b0, 4'h0, 1'b0);
    cyc(1'b0, 4'h0, 1'b0);
    cyc(1'b0, 4'h0, 1'b1);
    chk("s1_event_count", ev_count - e0, 1);

    // three frames then empty: rejected
    e0 = ev_count;
    repeat (3) frame_key(4'h5);
    repeat (3) frame_empty();
    chk("s2_event_count", ev_count - e0, 0);
    chk("s2_down", int'(key_down), 0);

    // held key with a release bounce
    e0 = ev_count;
    repeat (4) frame_key(4'h5);
    frame_empty();
    frame_key(4'h5);
    repeat (3) frame_empty();
    chk("s3_down_held", int'(key_down), 1);
    frame_empty();
    cyc(1'b0, 4'h0, 1'b0);
    chk("s3_down_released", int'(key_down), 0);
    cyc(1'b0, 4'h0, 1'b0);
    cyc(1'b0, 4'h0, 1'b0);
    cyc(1'b0, 4'h0, 1'b1);
    chk("s3_event_count", ev_count - e0, 1);

    // two keys per frame
    e0 = ev_count;
    repeat (6) frame_multi(4'h2, 4'h9);
    repeat (2) frame_empty();
    chk("s4_event_count", ev_count - e0, 0);
    chk("s4_down", int'(key_down), 0);

    // consumer stalled: second press is dropped
    key_ready = 1'b0;
    o0 = ovr_count;
    repeat (4) frame_key(4'h3);
    repeat (4) frame_empty();
    repeat (4) frame_key(4'h7);
    repeat (2) frame_empty();
    chk("s5_valid", int'(key_valid), 1);
    chk("s5_code", int'(key_code), 3);
    chk("s5_overrun_pulses", ovr_count - o0, 1);
    repeat (4) frame_empty();
    key_ready = 1'b1;
    frame_empty();
    chk("s5_drained", int'(key_valid), 0);

    // reset during press qualification
    key_ready = 1'b0;
    repeat (4) frame_key(4'hC);
    repeat (4) frame_empty();
    frame_key(4'hA);
    frame_key(4'hA);
    cyc(1'b0, 4'h0, 1'b0);
    cyc(1'b1, 4'hA, 1'b0);
    chk("s6_valid_before_reset", int'(key_valid), 1);
    reset = 1'b1;
    #1;
    chk("s6_async_valid", int'(key_valid), 0);
    chk("s6_async_code", int'(key_code), 0);
    chk("s6_async_down", int'(key_down), 0);
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    key_ready = 1'b1;
    e0 = ev_count;
    repeat (3) frame_key(4'hA);
    frame_key(4'hA);
    chk("s6_no_event_after_3", ev_count - e0, 0);
    repeat (2) frame_empty();
    chk("s6_event_after_4", ev_count - e0, 1);
    chk("s6_code", int'(key_code), 10);
    repeat (4) frame_empty();

    // randomized traffic against the model
    rand_ready = 1'b1;
    cur_key = 4'h6;
    for (int n = 0; n < 600; n++) begin
      if (n == 300) begin
        cyc(1'b1, cur_key, 1'b0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
      end
      frame_random(cur_key);
    end
    rand_ready = 1'b0;
    key_ready = 1'b1;
    repeat (6) frame_empty();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
